fetch_stage: RTL and testbench

Instruction-fetch stage of the pipelined RV32I core: owns the PC, issues reads to the instruction cache, and drives the IF/ID pipeline register that feeds the decode stage. It absorbs variable instruction-memory latency, honours pipeline stalls from the hazard unit, and services branch/jump redirects from execute, including discarding responses to requests that a redirect has made stale.

---
 rtl/fetch_stage_pkg.sv | 11 +
 rtl/fetch_stage_if_id_reg.sv | 17 +
 rtl/fetch_stage.sv | 91 +++++++++
 tb/tb_fetch_stage.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
// fetch_stage_pkg: shared fetch-stage types and constants
package fetch_stage_pkg;
  localparam logic [31:0] RV32I_NOP = 32'h0000_0013;
  typedef enum logic [1:0] {FETCH, DISCARD, HOLD} fetch_state_t;
  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] instr;
  } if_id_t;
  localparam if_id_t IF_ID_BUBBLE = '{valid: 1'b0, pc: 32'h0, instr: RV32I_NOP};
endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// fetch_stage_if_id_reg: IF/ID pipeline register with flush, hold and load controls
module fetch_stage_if_id_reg
  import fetch_stage_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   flush,
  input  logic   hold,
  input  logic   load,
  input  if_id_t d,
  output if_id_t q
);
  // flush beats hold; with nothing to deliver a bubble is loaded
  always_ff @(posedge clk)
    if (rst || flush) q <= IF_ID_BUBBLE;
    else if (!hold) q <= load ? d : IF_ID_BUBBLE;
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: RV32I instruction fetch with PC, stale-response discard and stall hold buffer
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h4000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic [31:0] imem_address,
  output logic        imem_read,
  input  logic [31:0] imem_rdata,
  input  logic        imem_resp,
  output logic        if_id_valid,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_instr
);
  fetch_state_t state, state_n;
  logic [31:0] pc, pc_n, hbuf, hbuf_n, pending_pc, pending_n, word, target;
  logic load;
  if_id_t q;
  assign target = {redirect_pc_i[31:2], 2'b00};
  assign imem_address = {pc[31:2], 2'b00};
  assign imem_read = !rst && state != HOLD;
  // next state, next pc and the word offered to IF/ID
  always_comb begin
    state_n = state;
    pc_n = pc;
    hbuf_n = hbuf;
    pending_n = pending_pc;
    load = 1'b0;
    word = hbuf;
    case (state)
      FETCH:
        if (redirect_i) begin
          pc_n = imem_resp ? target : pc;
          pending_n = imem_resp ? pending_pc : target;
          state_n = imem_resp ? FETCH : DISCARD;
        end else if (imem_resp && stall_i) begin
          hbuf_n = imem_rdata;
          state_n = HOLD;
        end else if (imem_resp) begin
          load = 1'b1;
          word = imem_rdata;
          pc_n = pc + 32'd4;
        end
      DISCARD:
        if (imem_resp) begin
          pc_n = redirect_i ? target : pending_pc;
          state_n = FETCH;
        end else if (redirect_i) pending_n = target;
      HOLD:
        if (redirect_i) begin
          pc_n = target;
          state_n = FETCH;
        end else if (!stall_i) begin
          load = 1'b1;
          pc_n = pc + 32'd4;
          state_n = FETCH;
        end
      default: state_n = FETCH;
    endcase
  end
  // fetch state registers
  always_ff @(posedge clk)
    if (rst) begin
      state <= FETCH;
      pc <= {RESET_PC[31:2], 2'b00};
      hbuf <= RV32I_NOP;
      pending_pc <= 32'h0;
    end else begin
      state <= state_n;
      pc <= pc_n;
      hbuf <= hbuf_n;
      pending_pc <= pending_n;
    end
  fetch_stage_if_id_reg u_if_id (
    .clk  (clk),
    .rst  (rst),
    .flush(redirect_i),
    .hold (stall_i),
    .load (load),
    .d    ('{valid: 1'b1, pc: pc, instr: word}),
    .q    (q)
  );
  assign if_id_valid = q.valid;
  assign if_id_pc = q.pc;
  assign if_id_instr = q.instr;
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed scenarios plus a randomized stream-level reference model
module tb_fetch_stage;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] RST_PC = 32'h4000_0000;
  localparam logic [64:0] BUBBLE = {1'b0, 32'h0, NOP};
  logic clk = 1'b0, rst = 1'b1, stall_i = 1'b0, redirect_i = 1'b0, imem_resp = 1'b0;
  logic [31:0] redirect_pc_i = 32'h0, imem_rdata = 32'h0;
  logic [31:0] imem_address, if_id_pc, if_id_instr;
  logic imem_read, if_id_valid;
  int pass_cnt = 0, total_cnt = 0;
  always #5 clk = ~clk;
  fetch_stage dut (
    .clk(clk), .rst(rst), .stall_i(stall_i), .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .imem_address(imem_address), .imem_read(imem_read), .imem_rdata(imem_rdata), .imem_resp(imem_resp),
    .if_id_valid(if_id_valid), .if_id_pc(if_id_pc), .if_id_instr(if_id_instr)
  );
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  function automatic logic [64:0] ifid();
    return {if_id_valid, if_id_pc, if_id_instr};
  endfunction
  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction
  task automatic test_reset;
    rst = 1'b1;
    tick();
    tick();
    total_cnt++; if (imem_read !== 1'b0) $display("FAIL reset_read: got %b want 0", imem_read); else pass_cnt++;
    total_cnt++; if (ifid() !== BUBBLE) $display("FAIL reset_ifid: got %h want %h", ifid(), BUBBLE); else pass_cnt++;
    total_cnt++; if (imem_address !== RST_PC) $display("FAIL reset_pc: got %h want %h", imem_address, RST_PC); else pass_cnt++;
    rst = 1'b0;
    #1;
    total_cnt++; if (imem_read !== 1'b1) $display("FAIL first_read: got %b want 1", imem_read); else pass_cnt++;
  endtask
  task automatic test_back_to_back;
    imem_resp = 1'b1;
    imem_rdata = 32'h0050_0093;
    tick();
    total_cnt++; if (ifid() !== {1'b1, 32'h4000_0000, 32'h0050_0093}) $display("FAIL b2b_first: got %h", ifid()); else pass_cnt++;
    total_cnt++; if (imem_address !== 32'h4000_0004) $display("FAIL b2b_addr1: got %h want 40000004", imem_address); else pass_cnt++;
    imem_rdata = 32'h00a0_0113;
    tick();
    total_cnt++; if (ifid() !== {1'b1, 32'h4000_0004, 32'h00a0_0113}) $display("FAIL b2b_second: got %h", ifid()); else pass_cnt++;
    total_cnt++; if (imem_address !== 32'h4000_0008) $display("FAIL b2b_addr2: got %h want 40000008", imem_address); else pass_cnt++;
  endtask
  task automatic test_latency;
    for (int i = 0; i < 4; i++) begin
      imem_resp = (i == 3);
      imem_rdata = (i == 3) ? 32'h0020_8233 : 32'hDEAD_0000;
      total_cnt++; if (imem_read !== 1'b1 || imem_address !== 32'h4000_0008) $display("FAIL lat_hold%0d: got read %b addr %h want 1 40000008", i, imem_read, imem_address); else pass_cnt++;
      tick();
      if (i < 3) begin
        total_cnt++; if (ifid() !== BUBBLE) $display("FAIL lat_bubble%0d: got %h want %h", i, ifid(), BUBBLE); else pass_cnt++;
      end
    end
    total_cnt++; if (ifid() !== {1'b1, 32'h4000_0008, 32'h0020_8233}) $display("FAIL lat_deliver: got %h", ifid()); else pass_cnt++;
    total_cnt++; if (imem_address !== 32'h4000_000C) $display("FAIL lat_next: got %h want 4000000c", imem_address); else pass_cnt++;
  endtask
  task automatic test_stall;
    imem_resp = 1'b1;
    stall_i = 1'b1;
    imem_rdata = 32'h0000_0463;
    tick();
    imem_resp = 1'b0;
    for (int i = 0; i < 2; i++) begin
      total_cnt++; if (imem_read !== 1'b0) $display("FAIL stall_read%0d: got %b want 0", i, imem_read); else pass_cnt++;
      total_cnt++; if (ifid() !== {1'b1, 32'h4000_0008, 32'h0020_8233}) $display("FAIL stall_hold%0d: got %h", i, ifid()); else pass_cnt++;
      tick();
    end
    stall_i = 1'b0;
    tick();
    total_cnt++; if (ifid() !== {1'b1, 32'h4000_000C, 32'h0000_0463}) $display("FAIL stall_release: got %h", ifid()); else pass_cnt++;
    total_cnt++; if (imem_read !== 1'b1 || imem_address !== 32'h4000_0010) $display("FAIL stall_next: got read %b addr %h want 1 40000010", imem_read, imem_address); else pass_cnt++;
  endtask
  task automatic test_redirect_outstanding;
    redirect_i = 1'b1;
    redirect_pc_i = 32'h4000_0080;
    tick();
    redirect_pc_i = 32'h4000_0103;
    total_cnt++; if (ifid() !== BUBBLE) $display("FAIL redir_bubble: got %h want %h", ifid(), BUBBLE); else pass_cnt++;
    total_cnt++; if (imem_read !== 1'b1 || imem_address !== 32'h4000_0010) $display("FAIL redir_held: got read %b addr %h", imem_read, imem_address); else pass_cnt++;
    tick();
    redirect_i = 1'b0;
    imem_resp = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    total_cnt++; if (imem_address !== 32'h4000_0010) $display("FAIL redir_held2: got %h want 40000010", imem_address); else pass_cnt++;
    tick();
    imem_resp = 1'b0;
    total_cnt++; if (ifid() !== BUBBLE) $display("FAIL redir_drop: got %h want %h", ifid(), BUBBLE); else pass_cnt++;
    total_cnt++; if (imem_address !== 32'h4000_0100) $display("FAIL redir_target: got %h want 40000100", imem_address); else pass_cnt++;
  endtask
  task automatic test_redirect_stall;
    imem_resp = 1'b1;
    stall_i = 1'b1;
    imem_rdata = 32'h00c0_0193;
    tick();
    imem_resp = 1'b0;
    redirect_i = 1'b1;
    redirect_pc_i = 32'h4000_0300;
    total_cnt++; if (imem_read !== 1'b0) $display("FAIL rs_hold_read: got %b want 0", imem_read); else pass_cnt++;
    tick();
    redirect_i = 1'b0;
    stall_i = 1'b0;
    total_cnt++; if (ifid() !== BUBBLE) $display("FAIL rs_bubble: got %h want %h", ifid(), BUBBLE); else pass_cnt++;
    total_cnt++; if (imem_read !== 1'b1 || imem_address !== 32'h4000_0300) $display("FAIL rs_target: got read %b addr %h", imem_read, imem_address); else pass_cnt++;
    imem_resp = 1'b1;
    imem_rdata = 32'h0040_0213;
    tick();
    imem_resp = 1'b0;
    total_cnt++; if (ifid() !== {1'b1, 32'h4000_0300, 32'h0040_0213}) $display("FAIL rs_deliver: got %h", ifid()); else pass_cnt++;
  endtask
  task automatic test_wrap_and_reset;
    redirect_i = 1'b1;
    imem_resp = 1'b1;
    redirect_pc_i = 32'hFFFF_FFFC;
    tick();
    redirect_i = 1'b0;
    imem_rdata = 32'h0000_0093;
    total_cnt++; if (imem_address !== 32'hFFFF_FFFC) $display("FAIL wrap_addr: got %h want fffffffc", imem_address); else pass_cnt++;
    tick();
    imem_resp = 1'b0;
    total_cnt++; if (ifid() !== {1'b1, 32'hFFFF_FFFC, 32'h0000_0093}) $display("FAIL wrap_deliver: got %h", ifid()); else pass_cnt++;
    total_cnt++; if (imem_address !== 32'h0) $display("FAIL wrap_next: got %h want 00000000", imem_address); else pass_cnt++;
    redirect_i = 1'b1;
    redirect_pc_i = 32'h4000_0400;
    tick();
    redirect_i = 1'b0;
    rst = 1'b1;
    tick();
    total_cnt++; if (imem_read !== 1'b0 || imem_address !== RST_PC) $display("FAIL midrst_pc: got read %b addr %h", imem_read, imem_address); else pass_cnt++;
    total_cnt++; if (ifid() !== BUBBLE) $display("FAIL midrst_ifid: got %h want %h", ifid(), BUBBLE); else pass_cnt++;
    rst = 1'b0;
    #1;
    total_cnt++; if (imem_read !== 1'b1) $display("FAIL midrst_read: got %b want 1", imem_read); else pass_cnt++;
  endtask
  task automatic test_random;
    logic [31:0] np, prev_addr;
    logic [64:0] expv;
    logic stale, held, prev_out;
    int wait_cnt, deliv;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    np = RST_PC;
    expv = BUBBLE;
    stale = 1'b0;
    held = 1'b0;
    prev_out = 1'b0;
    prev_addr = 32'h0;
    wait_cnt = 0;
    deliv = 0;
    for (int c = 0; c < 3000; c++) begin
      total_cnt++; if (ifid() !== expv) $display("FAIL rnd_ifid@%0d: got %h want %h", c, ifid(), expv); else pass_cnt++;
      total_cnt++; if (imem_address[1:0] !== 2'b00) $display("FAIL rnd_align@%0d: got %h", c, imem_address); else pass_cnt++;
      if (prev_out) begin
        total_cnt++; if (imem_read !== 1'b1 || imem_address !== prev_addr) $display("FAIL rnd_outstanding@%0d: got read %b addr %h want 1 %h", c, imem_read, imem_address, prev_addr); else pass_cnt++;
      end
      stall_i = ($urandom_range(0, 3) == 0);
      redirect_i = ($urandom_range(0, 11) == 0);
      redirect_pc_i = $urandom;
      imem_resp = imem_read && wait_cnt == 0;
      imem_rdata = imem_resp ? mem(imem_address) : $urandom;
      if (imem_read) wait_cnt = imem_resp ? int'($urandom_range(0, 3)) : wait_cnt - 1;
      prev_out = imem_read && !imem_resp;
      prev_addr = imem_address;
      if (redirect_i) begin
        expv = BUBBLE;
        held = 1'b0;
        stale = imem_read && !imem_resp;
        np = redirect_pc_i & 32'hFFFF_FFFC;
      end else if (stall_i) begin
        if (imem_resp) begin
          held = !stale;
          stale = 1'b0;
        end
      end else if (held || (imem_resp && !stale)) begin
        expv = {1'b1, np, mem(np)};
        np = np + 32'd4;
        held = 1'b0;
        deliv++;
      end else begin
        expv = BUBBLE;
        if (imem_resp) stale = 1'b0;
      end
      tick();
    end
    stall_i = 1'b0;
    redirect_i = 1'b0;
    imem_resp = 1'b0;
    total_cnt++; if (deliv < 200) $display("FAIL rnd_progress: got %0d deliveries want >= 200", deliv); else pass_cnt++;
  endtask
  initial begin
    test_reset();
    test_back_to_back();
    test_latency();
    test_stall();
    test_redirect_outstanding();
    test_redirect_stall();
    test_wrap_and_reset();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
